// File: rtl/msg_block_sequencer.sv
// Builds one padded SHA-256 block from byte memory; block_valid rises L+3 cycles after start (2 when L=0).
// Block and block_valid hold while block_ready is low; start is ignored until the sequencer is back in IDLE.
module msg_block_sequencer #(
  parameter int MSG_LENGTH = 55,
  parameter int ADDR_W     = $clog2(MSG_LENGTH),
  parameter int LEN_W      = $clog2(MSG_LENGTH + 1)
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [LEN_W-1:0]  msg_len_i,
  output logic              mem_rd_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [7:0]        mem_data_i,
  output logic              block_valid_o,
  input  logic              block_ready_i,
  output logic [511:0]      block_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  typedef enum logic [2:0] {IDLE, READ, LAST, PAD, OFFER, DONE} state_e;

  state_e              state_q;
  logic [LEN_W-1:0]    len_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                rd_en_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;
  logic                error_q;
  logic [511:0]        block_q;

  logic [ADDR_W-1:0]   cap_idx;
  logic [8:0]          cap_base;
  logic [8:0]          pad_base;
  logic                last_addr;

  // Read data trails the address by one cycle, so READ stores the previous byte and LAST the final one.
  assign cap_idx   = (state_q == LAST) ? addr_q : addr_q - ADDR_W'(1);
  assign cap_base  = 9'd511 - (9'(cap_idx) << 3);
  assign pad_base  = 9'd511 - (9'(len_q) << 3);
  assign last_addr = (addr_q == ADDR_W'(len_q - LEN_W'(1)));

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      len_q   <= '0;
      addr_q  <= '0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      block_q <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (msg_len_i > LEN_W'(MSG_LENGTH)) begin
              error_q <= 1'b1;
            end else begin
              len_q   <= msg_len_i;
              block_q <= '0;
              addr_q  <= '0;
              busy_q  <= 1'b1;
              if (msg_len_i == '0) begin
                state_q <= PAD;
              end else begin
                rd_en_q <= 1'b1;
                state_q <= READ;
              end
            end
          end
        end
        READ: begin
          if (addr_q != '0) block_q[cap_base -: 8] <= mem_data_i;
          if (last_addr) begin
            rd_en_q <= 1'b0;
            state_q <= LAST;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
        LAST: begin
          block_q[cap_base -: 8] <= mem_data_i;
          state_q <= PAD;
        end
        PAD: begin
          // The 0x80 byte sits at most at byte 55, clear of the 64-bit length field.
          block_q[pad_base -: 8] <= 8'h80;
          block_q[63:0]          <= 64'(len_q) << 3;
          valid_q                <= 1'b1;
          state_q                <= OFFER;
        end
        OFFER: begin
          if (block_ready_i) begin
            valid_q <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_rd_en_o   = rd_en_q;
  assign mem_addr_o    = addr_q;
  assign block_valid_o = valid_q;
  assign block_o       = block_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign error_o       = error_q;

endmodule

// File: tb/tb_msg_block_sequencer.sv
// Directed bench for msg_block_sequencer with a 1-cycle-latency byte memory model.
module tb_msg_block_sequencer;
  localparam int ML = 55;
  localparam int AW = $clog2(ML);
  localparam int LW = $clog2(ML + 1);

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] msg_len = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data = 8'h00;
  logic          block_valid;
  logic          block_ready = 1'b0;
  logic [511:0]  block;
  logic          busy;
  logic          done;
  logic          error;

  msg_block_sequencer #(.MSG_LENGTH(ML)) dut (
    .clock_i      (clock),
    .reset_i      (reset),
    .start_i      (start),
    .msg_len_i    (msg_len),
    .mem_rd_en_o  (mem_rd_en),
    .mem_addr_o   (mem_addr),
    .mem_data_i   (mem_data),
    .block_valid_o(block_valid),
    .block_ready_i(block_ready),
    .block_o      (block),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [0:63];
  always @(posedge clock) if (mem_rd_en) mem_data <= mem[mem_addr];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int viol     = 0;
  int cur_len  = 0;
  int addr_log[$];

  always @(posedge clock) begin
    if (mem_rd_en) begin
      addr_log.push_back(int'(mem_addr));
      if (block_valid) viol++;
      if (int'(mem_addr) > cur_len - 1) viol++;
    end
  end
  always @(negedge clock) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the bench at the falling edge of cycle 1 (start sampled at edge 0).
  task automatic issue(input int len);
    @(negedge clock);
    cur_len = len;
    addr_log.delete();
    viol    = 0;
    start   = 1'b1;
    msg_len = LW'(len);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int exp_cyc);
    int cyc = 1;
    while (!block_valid && cyc < 200) begin
      @(negedge clock);
      cyc++;
    end
    chk(tag, 512'(cyc), 512'(exp_cyc));
  endtask

  task automatic load_abc();
    mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
  endtask

  logic [511:0] abc_blk   = {32'h61626380, 416'b0, 64'h18};
  logic [511:0] hello_blk = {48'h68656c6c6f80, 400'b0, 64'h28};
  logic [511:0] exp_blk;
  logic [511:0] snap;
  int           dc;
  int           changed;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;

    @(negedge clock);
    chk("reset_outs", 512'({mem_rd_en, mem_addr, block_valid, busy, done, error}), 512'(0));
    chk("reset_block", block, 512'(0));
    reset = 1'b0;

    // "abc", ready held high
    load_abc();
    block_ready = 1'b1;
    issue(3);
    wait_valid("abc_latency", 6);
    chk("abc_block", block, abc_blk);
    chk("abc_addrs", 512'({32'(addr_log.size()), 32'(addr_log[0]), 32'(addr_log[1]), 32'(addr_log[2])}),
        512'({32'd3, 32'd0, 32'd1, 32'd2}));
    @(negedge clock);
    chk("abc_done", 512'({done, block_valid, busy}), 512'(3'b101));
    @(negedge clock);
    chk("abc_done_end", 512'({done, busy}), 512'(2'b00));
    chk("abc_mem_rules", 512'(viol), 512'(0));

    // empty message
    issue(0);
    wait_valid("empty_latency", 2);
    chk("empty_block", block, {1'b1, 511'b0});
    chk("empty_no_reads", 512'(addr_log.size()), 512'(0));
    @(negedge clock);
    chk("empty_done", 512'(done), 512'(1));
    @(negedge clock);
    chk("empty_done_end", 512'(done), 512'(0));

    // maximum length, byte i = i
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    exp_blk = '0;
    for (int i = 0; i < 55; i++) exp_blk[511 - 8*i -: 8] = 8'(i);
    exp_blk[511 - 8*55 -: 8] = 8'h80;
    exp_blk[63:0] = 64'h1B8;
    issue(55);
    wait_valid("max_latency", 58);
    chk("max_block", block, exp_blk);
    chk("max_addrs", 512'({32'(addr_log.size()), 32'(addr_log[54])}), 512'({32'd55, 32'd54}));
    chk("max_mem_rules", 512'(viol), 512'(0));
    repeat (2) @(negedge clock);

    // backpressure with a stray start during OFFER
    mem[0] = 8'h68; mem[1] = 8'h65; mem[2] = 8'h6c; mem[3] = 8'h6c; mem[4] = 8'h6f;
    block_ready = 1'b0;
    issue(5);
    wait_valid("bp_latency", 8);
    chk("bp_block", block, hello_blk);
    snap    = block;
    dc      = done_cnt;
    changed = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin start = 1'b1; msg_len = LW'(1); end
      if (k == 4) start = 1'b0;
      @(negedge clock);
      if (block !== snap || !block_valid || done) changed++;
    end
    chk("bp_stable", 512'(changed), 512'(0));
    block_ready = 1'b1;
    @(negedge clock);
    chk("bp_done", 512'({done, block_valid}), 512'(2'b10));
    block_ready = 1'b0;
    @(negedge clock);
    chk("bp_done_pulses", 512'({32'(done_cnt - dc), 31'd0, done}), 512'({32'd1, 32'd0}));
    @(negedge clock);
    chk("bp_idle_hold", {block[511:1] ^ snap[511:1], busy}, 512'(0));

    // oversize length
    issue(56);
    chk("err_pulse", 512'({error, busy, mem_rd_en, block_valid}), 512'(4'b1000));
    @(negedge clock);
    chk("err_end", 512'({error, busy, mem_rd_en, block_valid}), 512'(0));

    // asynchronous reset in the middle of READ
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    issue(20);
    repeat (5) @(negedge clock);
    dc = done_cnt;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_outs", 512'({mem_rd_en, mem_addr, block_valid, busy, done, error}), 512'(0));
    chk("async_rst_block", block, 512'(0));
    @(negedge clock);
    reset = 1'b0;
    chk("async_rst_no_done", 512'(done_cnt - dc), 512'(0));
    load_abc();
    block_ready = 1'b1;
    issue(3);
    wait_valid("post_rst_latency", 6);
    chk("post_rst_block", block, abc_blk);
    @(negedge clock);
    chk("post_rst_done", 512'(done), 512'(1));
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
